// File: rtl/step_move_scheduler_if.sv
// Move-command handshake: valid/ready carrying step count, half-period and direction.
interface step_move_scheduler_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_half;
  logic             cmd_dir;

  modport master (output cmd_valid, cmd_steps, cmd_half, cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, cmd_steps, cmd_half, cmd_dir, output cmd_ready);
endinterface

// File: rtl/step_move_scheduler.sv
// Stepper-axis move scheduler: one pending command slot feeding an IDLE/SETUP/HIGH/LOW pulse FSM.
// First STEP rise two cycles after handshake (+DIR_SETUP on a direction change); ready drops while the slot is full or abort is high.
module step_move_scheduler #(
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 8,
  parameter int DIR_SETUP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  step_move_scheduler_if.slave cmd,
  input  logic                 abort,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 busy,
  output logic                 move_done,
  output logic [CNT_W-1:0]     steps_left
);
  localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;

  state_e             state_q, state_d;
  logic               pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]   pend_steps_q, pend_steps_d;
  logic [DIV_W-1:0]   pend_half_q, pend_half_d;
  logic               pend_dir_q, pend_dir_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [DIV_W-1:0]   half_q, half_d;
  logic [DIV_W-1:0]   ph_q, ph_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               dir_q, dir_d;
  logic               dir_known_q, dir_known_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               accept;
  logic               pop;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pend_vld_q && pend_steps_q != '0)
               state_d = (!dir_known_q || pend_dir_q != dir_q) ? SETUP : HIGH;
      SETUP: if (set_q == SET_LAST) state_d = HIGH;
      HIGH:  if (ph_q == '0) state_d = LOW;
      LOW:   if (ph_q == '0) state_d = (steps_q == '0) ? IDLE : HIGH;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    cmd.cmd_ready = !pend_vld_q && !abort;
    busy          = (state_q != IDLE) || pend_vld_q;
    step_out      = step_q;
    dir_out       = dir_q;
    move_done     = done_q;
    steps_left    = steps_q;
  end

  assign accept = cmd.cmd_valid && !pend_vld_q && !abort;
  assign pop    = (state_q == IDLE) && pend_vld_q;

  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_steps_d = pend_steps_q;
    pend_half_d  = pend_half_q;
    pend_dir_d   = pend_dir_q;
    steps_d      = steps_q;
    half_d       = half_q;
    ph_d         = ph_q;
    set_d        = '0;
    dir_d        = dir_q;
    dir_known_d  = dir_known_q;
    done_d       = 1'b0;
    if (pop) begin
      pend_vld_d = 1'b0;
      half_d     = (pend_half_q == '0) ? DIV_W'(1) : pend_half_q;
      steps_d    = pend_steps_q;
      // A zero-step move completes at once and must not disturb the DIR pin.
      if (pend_steps_q == '0) done_d = 1'b1;
      else begin
        dir_d       = pend_dir_q;
        dir_known_d = 1'b1;
      end
    end
    if (accept) begin
      pend_vld_d   = 1'b1;
      pend_steps_d = cmd.cmd_steps;
      pend_half_d  = cmd.cmd_half;
      pend_dir_d   = cmd.cmd_dir;
    end
    if (state_q == SETUP) set_d = set_q + SET_W'(1);
    if (state_q == HIGH && state_d == LOW && steps_q != '0) steps_d = steps_q - CNT_W'(1);
    if (state_q == LOW && state_d == IDLE) done_d = 1'b1;
    if (state_d == HIGH || state_d == LOW)
      ph_d = (state_d != state_q) ? half_d - DIV_W'(1) : ph_q - DIV_W'(1);
    if (abort) begin
      pend_vld_d  = 1'b0;
      steps_d     = '0;
      done_d      = 1'b0;
      dir_d       = dir_q;
      dir_known_d = dir_known_q;
    end
    step_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q   <= 1'b0;
      pend_steps_q <= '0;
      pend_half_q  <= '0;
      pend_dir_q   <= 1'b0;
      steps_q      <= '0;
      half_q       <= '0;
      ph_q         <= '0;
      set_q        <= '0;
      dir_q        <= 1'b0;
      dir_known_q  <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_steps_q <= pend_steps_d;
      pend_half_q  <= pend_half_d;
      pend_dir_q   <= pend_dir_d;
      steps_q      <= steps_d;
      half_q       <= half_d;
      ph_q         <= ph_d;
      set_q        <= set_d;
      dir_q        <= dir_d;
      dir_known_q  <= dir_known_d;
      step_q       <= step_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_step_move_scheduler.sv
// Directed bench for step_move_scheduler: per-cycle vector table plus abort / reset sequences.
module tb_step_move_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        step_out, dir_out, busy, move_done;
  logic [15:0] steps_left;
  int          n_cmp = 0;
  int          n_err = 0;

  step_move_scheduler_if #(.CNT_W(16), .DIV_W(8)) cmd_if ();

  step_move_scheduler #(.CNT_W(16), .DIV_W(8), .DIR_SETUP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .abort      (abort),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .move_done  (move_done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // One record covers n consecutive cycles with identical inputs and expected outputs.
  typedef struct {
    logic v; int st; int hf; logic d; logic ab; logic rs; int n;
    logic e_step; logic e_dir; logic e_busy; logic e_done; int e_sl; logic e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input int st, input int hf, input logic d,
                     input logic ab, input logic rs, input int n,
                     input logic es, input logic ed, input logic eb, input logic edn,
                     input int esl, input logic er);
    vec_t r;
    r.v = v; r.st = st; r.hf = hf; r.d = d; r.ab = ab; r.rs = rs; r.n = n;
    r.e_step = es; r.e_dir = ed; r.e_busy = eb; r.e_done = edn; r.e_sl = esl; r.e_rdy = er;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input int st, input int hf, input logic d);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_steps = 16'(st);
    cmd_if.cmd_half  = 8'(hf);
    cmd_if.cmd_dir   = d;
  endtask

  task automatic chk_all(input string tag, input logic es, input logic ed, input logic eb,
                         input logic edn, input int esl, input logic er);
    chk($sformatf("%s.step", tag), step_out, es);
    chk($sformatf("%s.dir", tag), dir_out, ed);
    chk($sformatf("%s.busy", tag), busy, eb);
    chk($sformatf("%s.done", tag), move_done, edn);
    chk($sformatf("%s.left", tag), steps_left, 32'(esl));
    chk($sformatf("%s.rdy", tag), cmd_if.cmd_ready, er);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    abort = 1'b0;
    drive(0, 0, 0, 0);

    //   v st hf d ab rs  n  step dir busy done left rdy
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);   // out of reset
    // steps=3 half=2 dir=1: first direction set -> SETUP
    add(1, 3, 2, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4,  0, 1, 1, 0, 3, 1);
    add(0, 0, 0, 0, 0, 0, 2,  1, 1, 1, 0, 3, 1);
    add(0, 0, 0, 0, 0, 0, 2,  0, 1, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 2,  1, 1, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 2,  0, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 2,  1, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 2,  0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1);
    // back-to-back same direction: steps=2 half=1 then steps=1 half=3
    add(1, 2, 1, 1, 0, 0, 1,  0, 1, 0, 0, 0, 1);
    add(1, 1, 3, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    add(1, 1, 3, 1, 0, 0, 1,  1, 1, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3,  1, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 3,  0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1);
    // direction reversal: steps=1 half=1 dir=0
    add(1, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4,  0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    // zero-step move with a different dir: done at once, dir_out unchanged
    add(1, 0, 5, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    // half=0 behaves as half=1
    add(1, 2, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);

    repeat (3) tick();

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        drive(tbl[i].v, tbl[i].st, tbl[i].hf, tbl[i].d);
        abort = tbl[i].ab;
        rst   = tbl[i].rs;
        #1;
        chk_all($sformatf("row%0d.%0d", i, j), tbl[i].e_step, tbl[i].e_dir, tbl[i].e_busy,
                tbl[i].e_done, tbl[i].e_sl, tbl[i].e_rdy);
        tick();
      end
    end

    // abort during 2nd of 5 pulses with a pending command
    drive(1, 5, 2, 0); #1;
    chk("ab.rdy_first", cmd_if.cmd_ready, 1); tick();
    drive(0, 0, 0, 0); #1;
    chk("ab.rdy_pend", cmd_if.cmd_ready, 0); tick();
    drive(1, 3, 1, 0); #1;
    chk("ab.rdy_second", cmd_if.cmd_ready, 1);
    chk("ab.first_rise", step_out, 1); tick();
    drive(0, 0, 0, 0);
    k = 0;
    while (!(step_out === 1'b1 && steps_left == 16'd4) && k < 40) begin tick(); k++; end
    chk("ab.wait_pulse2", k < 40, 1);
    abort = 1'b1;
    drive(1, 7, 1, 1); #1;
    chk("ab.rdy_during", cmd_if.cmd_ready, 0);
    chk("ab.busy_before", busy, 1); tick();
    abort = 1'b0;
    drive(0, 0, 0, 0); #1;
    chk_all("ab.after", 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("ab.quiet%0d.done", j), move_done, 0);
      chk($sformatf("ab.quiet%0d.step", j), step_out, 0);
    end

    // reset in the middle of a HIGH phase
    tick();
    drive(1, 3, 4, 1); #1;
    chk("rs.rdy_first", cmd_if.cmd_ready, 1); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 2, 1, 1); #1;
    chk("rs.rdy_second", cmd_if.cmd_ready, 1); tick();
    drive(0, 0, 0, 0);
    k = 0;
    while (step_out !== 1'b1 && k < 40) begin tick(); k++; end
    chk("rs.wait_high", k < 40, 1);
    tick();
    chk("rs.dir_before", dir_out, 1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk_all("rs.after", 0, 0, 0, 0, 0, 1);
    tick();

    // after reset the direction is unknown, so even an unchanged dir goes through SETUP
    drive(1, 1, 1, 0); #1; tick();
    drive(0, 0, 0, 0); #1;
    chk("dk.busy", busy, 1);
    chk("dk.step_n1", step_out, 0); tick(); #1;
    chk("dk.step_n2", step_out, 0);
    chk("dk.left_n2", steps_left, 1);
    repeat (3) tick(); #1;
    chk("dk.step_n5", step_out, 0); tick(); #1;
    chk("dk.step_n6", step_out, 1); tick();
    tick(); #1;
    chk("dk.done_n8", move_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
